// File: rtl/byte_demux_4.sv
// rtl/byte_demux_4.sv - 1-to-4 byte lane demultiplexer and word assembler with a stall-able output register
module byte_demux_4 #(
    parameter int NBITS      = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NBITS/4-1:0]   i_byte,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_flush,
    output logic [NBITS-1:0]     o_word,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [1:0]           o_lane,
    output logic                 o_busy
);

    localparam int LW = NBITS / 4;

    logic [NBITS-1:0] fill_q, fill_d;
    logic [1:0]       lane_q, lane_d;
    logic [NBITS-1:0] word_q, word_d;
    logic             valid_q, valid_d;

    logic [NBITS-1:0] merged;
    logic [1:0]       slot;
    logic             accept;

    // The completing byte waits only while the previous word is still undrained
    assign o_ready = i_rst_n && !i_flush && !(lane_q == 2'd3 && valid_q && !i_ready);
    assign accept  = i_valid && o_ready;

    // Fill register with the incoming byte written into its lane slot
    always_comb begin
        merged = fill_q;
        slot   = BIG_ENDIAN ? (2'd3 - lane_q) : lane_q;
        for (int k = 0; k < 4; k++) begin
            if (slot == 2'(k)) begin
                merged[k*LW +: LW] = i_byte;
            end
        end
    end

    // Next-state: drain, flush, byte accept and word completion
    always_comb begin
        fill_d  = fill_q;
        lane_d  = lane_q;
        word_d  = word_q;
        valid_d = valid_q;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (i_flush) begin
            fill_d = '0;
            lane_d = 2'd0;
        end else if (accept) begin
            if (lane_q == 2'd3) begin
                // Fill restarts from zero so the next word carries no stale lanes
                word_d  = merged;
                valid_d = 1'b1;
                fill_d  = '0;
                lane_d  = 2'd0;
            end else begin
                fill_d = merged;
                lane_d = lane_q + 2'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fill_q  <= '0;
            lane_q  <= 2'd0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign o_word  = word_q;
    assign o_valid = valid_q;
    assign o_lane  = lane_q;
    assign o_busy  = (lane_q != 2'd0) || valid_q;

endmodule

// File: tb/tb_byte_demux_4.sv
// tb/tb_byte_demux_4.sv - randomized bench for byte_demux_4 against a byte-queue reference model
module tb_byte_demux_4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        valid_in, ready_in, flush_in;

    logic        be_ready, be_valid, be_busy;
    logic [31:0] be_word;
    logic [1:0]  be_lane;
    logic        le_ready, le_valid, le_busy;
    logic [31:0] le_word;
    logic [1:0]  le_lane;

    int n_vec = 0;
    int n_err = 0;

    // reference model: bytes of the word under assembly, pending output word
    logic [7:0]  mq[$];
    logic [31:0] m_be, m_le;
    bit          m_pv;

    always #5 clk = ~clk;

    byte_demux_4 #(.NBITS(32), .BIG_ENDIAN(1'b1)) u_be (
        .i_clk(clk), .i_rst_n(rst_n), .i_byte(byte_in), .i_valid(valid_in),
        .o_ready(be_ready), .i_flush(flush_in), .o_word(be_word), .o_valid(be_valid),
        .i_ready(ready_in), .o_lane(be_lane), .o_busy(be_busy)
    );

    byte_demux_4 #(.NBITS(32), .BIG_ENDIAN(1'b0)) u_le (
        .i_clk(clk), .i_rst_n(rst_n), .i_byte(byte_in), .i_valid(valid_in),
        .o_ready(le_ready), .i_flush(flush_in), .o_word(le_word), .o_valid(le_valid),
        .i_ready(ready_in), .o_lane(le_lane), .o_busy(le_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_be = '0;
        m_le = '0;
        m_pv = 1'b0;
    endtask

    // Drive one cycle of inputs, compare outputs before the edge, advance the model on the edge
    task automatic cycle(input logic v, input logic [7:0] b, input logic rdy,
                         input logic fl, input logic rn);
        bit e_ready, acc;
        @(negedge clk);
        valid_in = v; byte_in = b; ready_in = rdy; flush_in = fl; rst_n = rn;
        #1;
        if (!rn) model_reset();
        e_ready = rn && !fl && !(mq.size() == 3 && m_pv && !rdy);
        chk("be_ready", 32'(be_ready), 32'(e_ready));
        chk("le_ready", 32'(le_ready), 32'(e_ready));
        chk("be_valid", 32'(be_valid), 32'(m_pv));
        chk("le_valid", 32'(le_valid), 32'(m_pv));
        chk("be_word", be_word, m_be);
        chk("le_word", le_word, m_le);
        chk("be_lane", 32'(be_lane), 32'(mq.size()));
        chk("le_lane", 32'(le_lane), 32'(mq.size()));
        chk("be_busy", 32'(be_busy), 32'(mq.size() != 0 || m_pv));
        chk("le_busy", 32'(le_busy), 32'(mq.size() != 0 || m_pv));
        @(posedge clk);
        if (rn) begin
            acc = v && e_ready;
            if (m_pv && rdy) m_pv = 1'b0;
            if (fl) begin
                mq.delete();
            end else if (acc) begin
                mq.push_back(b);
                if (mq.size() == 4) begin
                    m_be = {mq[0], mq[1], mq[2], mq[3]};
                    m_le = {mq[3], mq[2], mq[1], mq[0]};
                    m_pv = 1'b1;
                    mq.delete();
                end
            end
        end
    endtask

    initial begin
        logic [7:0] seq[4];
        int rprob;
        rst_n = 1'b0; byte_in = '0; valid_in = 1'b0; ready_in = 1'b0; flush_in = 1'b0;
        model_reset();

        // reset state
        cycle(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // endian assembly
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b1, 1'b0, 1'b1);
        #1;
        chk("deadbeef_be", be_word, 32'hDEADBEEF);
        chk("deadbeef_le", le_word, 32'hEFBEADDE);
        chk("deadbeef_v", 32'(be_valid), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // backpressure: 0x08 stalls until the first word drains
        for (int k = 1; k <= 7; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h08, 1'b1, 1'b0, 1'b1);
        #1;
        chk("bp_word", be_word, 32'h05060708);
        chk("bp_valid", 32'(be_valid), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // flush discards the partial word
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'hBB, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'hCC, 1'b1, 1'b1, 1'b1);
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b1, 1'b0, 1'b1);
        #1;
        chk("flush_word", be_word, 32'h11223344);

        // async reset mid-word, then a clean word
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'h93, 1'b1, 1'b0, 1'b0);
        seq = '{8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b1, 1'b0, 1'b1);
        #1;
        chk("rst_word", be_word, 32'h55667788);

        // randomized traffic with varying downstream pressure
        for (int blk = 0; blk < 12; blk++) begin
            rprob = $urandom_range(10, 100);
            for (int c = 0; c < 60; c++) begin
                cycle($urandom_range(0, 99) < 75,
                      8'($urandom),
                      $urandom_range(1, 100) <= rprob,
                      $urandom_range(0, 19) == 0,
                      $urandom_range(0, 79) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/byte_demux_4.md
# byte_demux_4

Sequential 1-to-4 lane demultiplexer and word assembler for the debug unit's load path. Accepts a stream of NBITS/4-bit bytes under a valid/ready handshake and steers each byte into one of four lanes of a word register. It presents each completed NBITS-bit word on a registered, stall-able output handshake. It sits between the debug UART receiver and the instruction/data memory write port, and is the counterpart of the 4:1 operand/word selectors used in the datapath.

## Interface
- NBITS, 32, output word width; must be a multiple of 4. Lane width LW = NBITS/4.
- BIG_ENDIAN, 1, lane ordering:
  - 1: first byte of a word goes to bits [NBITS-1 -: LW].
  - 0: first byte of a word goes to bits [LW-1:0].

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_byte  in  LW  input byte.
- i_valid  in  1  i_byte valid.
- o_ready  out  1  byte accepted on a cycle with i_valid && o_ready.
- i_flush  in  1  discards the partially assembled word.
- o_word  out  NBITS  assembled word.
- o_valid  out  1  o_word valid; the word transfers on a cycle with o_valid && i_ready.
- i_ready  in  1  downstream ready.
- o_lane  out  2  lane index the next accepted byte will fill (0..3).
- o_busy  out  1  high when o_lane != 0 or o_valid.

## Operation
- Internal state:
  - fill register (NBITS).
  - 2-bit lane counter.
  - output register o_word.
  - flag o_valid.
- Byte accept (i_valid && o_ready):
  - write i_byte into the lane selected by the lane counter and BIG_ENDIAN.
  - increment the lane counter mod 4.
- Accepting into lane 3 completes the word. On the next edge:
  - o_word <= the fill register with lane 3 merged in.
  - o_valid <= 1.
  - lane counter <= 0.
- o_ready = i_rst_n && !i_flush && !(lane == 3 && o_valid && !i_ready).
  - Lanes 0..2 always fill while the output is stalled (one word of buffering).
  - The completing byte stalls only while the previous word is undrained.
- Output drain (o_valid && i_ready):
  - o_valid <= 0, unless a word completes on the same edge.
  - If a word completes on that edge, o_word is replaced with the new word and o_valid stays 1.
- o_word and o_valid are held stable while o_valid && !i_ready.
- i_flush:
  - on the edge, lane counter <= 0 and the fill register is cleared.
  - A pending o_word / o_valid is unaffected.
  - A byte presented during flush is not accepted (o_ready = 0).
- Unwritten fill lanes are 0; o_word carries no stale lanes.

## Timing
- Reset (async assert, any time, including mid-word):
  - o_word = 0, o_valid = 0, o_lane = 0, o_busy = 0.
  - Fill register cleared.
  - o_ready = 0 while i_rst_n is low.
- Reset release: o_ready = 1 from the first cycle after deassertion (subject to i_flush). Deassertion is assumed synchronised externally.
- Throughput: one byte per cycle; one word per 4 cycles sustained.
- Latency: o_valid rises the cycle after the 4th byte is accepted.
- o_lane and o_busy are registered-state decodes with no combinational input path. o_ready is combinational from i_ready and i_flush.
- Boundary cases:
  - Lane 3 accept and output drain on the same edge: both happen, no bubble.
  - Flush on the same cycle as a lane-3 byte: flush wins; no word is produced.
  - i_valid low mid-word: the partial word is held indefinitely (no timeout).

## Test plan
- Big-endian assembly: NBITS=32, BIG_ENDIAN=1, i_ready=1, bytes 0xDE, 0xAD, 0xBE, 0xEF on consecutive cycles -> o_word=0xDEADBEEF with o_valid for exactly 1 cycle, the cycle after 0xEF; o_lane steps 1, 2, 3, 0.
- Little-endian: same bytes with BIG_ENDIAN=0 -> o_word=0xEFBEADDE.
- Backpressure: i_ready=0, offer 0x01..0x08 continuously:
  - o_word=0x01020304 is held; 0x05..0x07 are accepted.
  - o_ready=0 while 0x08 is presented.
  - Raise i_ready for 1 cycle -> 0x08 is accepted on that cycle; the next cycle o_word=0x05060708, o_valid=1.
- Flush: accept 0xAA, 0xBB, assert i_flush 1 cycle (offering 0xCC, not accepted), then 0x11, 0x22, 0x33, 0x44 -> a single word 0x11223344; o_lane=0 after the flush.
- Async reset mid-word: reset after 3 bytes between clock edges -> all outputs 0 immediately; after release, bytes 0x55, 0x66, 0x77, 0x88 -> 0x55667788 with no residue.
- Drain/complete collision: o_valid=1 with i_ready=1 on the cycle the lane-3 byte is accepted -> o_valid stays 1 and o_word updates to the new word on the next edge.
